// File: rtl/msk_pkg.sv
// Shared types and sizing helpers for the masked share encoder.
package msk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StEnc,
    StOut
  } msk_enc_state_t;

  function automatic int unsigned nrnd(input int unsigned d, input int unsigned count);
    return (d - 1) * count;
  endfunction

  function automatic int unsigned nbeats(input int unsigned d, input int unsigned count,
                                         input int unsigned rnd_w);
    return (nrnd(d, count) + rnd_w - 1) / rnd_w;
  endfunction

  // Bit i of share j in the interleaved MSKxor layout.
  function automatic int unsigned sh_idx(input int unsigned i, input int unsigned j,
                                         input int unsigned d);
    return i * d + j;
  endfunction

endpackage

// File: rtl/msk_rnd_gather.sv
// Collects PRNG beats into one randomness word while the encoder is filling.
module msk_rnd_gather
  import msk_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned COUNT = 8,
  parameter int unsigned RND_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic [RND_W-1:0]             rnd_data,
  input  logic                         rnd_valid,
  input  logic                         rnd_ready,
  output logic                         done,
  output logic [nrnd(d, COUNT)-1:0]    rnd_bus
);

  localparam int unsigned NRND   = nrnd(d, COUNT);
  localparam int unsigned NBEATS = nbeats(d, COUNT, RND_W);
  localparam int unsigned CW     = $clog2(NBEATS + 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  (* keep = "true" *) logic [NRND-1:0] rnd_q;
  logic [NRND-1:0] rnd_d;
  logic            beat;

  assign beat    = rnd_valid && rnd_ready;
  assign done    = beat && (cnt_q == CW'(NBEATS - 1));
  assign rnd_bus = rnd_q;

  always_comb begin
    cnt_d = cnt_q;
    rnd_d = rnd_q;
    if (clear) begin
      cnt_d = '0;
      rnd_d = '0;
    end else if (start) begin
      cnt_d = '0;
    end else if (beat) begin
      // Bits of the last beat beyond NRND have no home and are dropped here.
      for (int p = 0; p < NRND; p++) begin
        if (cnt_q == CW'(p / RND_W)) begin
          rnd_d[p] = rnd_data[p % RND_W];
        end
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      rnd_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rnd_q <= rnd_d;
    end
  end

endmodule

// File: rtl/msk_share_encoder.sv
// Turns plain words into registered d-share Boolean sharings using gathered PRNG bits.
module msk_share_encoder
  import msk_pkg::*;
#(
  parameter int unsigned d     = 2,
  parameter int unsigned COUNT = 8,
  parameter int unsigned RND_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COUNT-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  (* fv_type = "random" *)
  input  logic [RND_W-1:0]       rnd_data,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  (* fv_type = "sharing", fv_count = COUNT *)
  output logic [COUNT*d-1:0]     out_sh,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned NRND = nrnd(d, COUNT);

  msk_enc_state_t state_q, state_d;
  (* keep = "true" *) logic [COUNT-1:0]   data_q;
  logic [COUNT-1:0]   data_d;
  (* keep = "true" *) logic [COUNT*d-1:0] out_q;
  logic [COUNT*d-1:0] out_d;
  logic [COUNT*d-1:0] enc_sh;
  logic [NRND-1:0]    rnd_bus;
  logic               start, clear, done;

  msk_rnd_gather #(
    .d     (d),
    .COUNT (COUNT),
    .RND_W (RND_W)
  ) u_gather (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .done      (done),
    .rnd_bus   (rnd_bus)
  );

  // Share forming only feeds the output register; data and randomness meet nowhere else.
  always_comb begin
    logic acc;
    enc_sh = '0;
    for (int i = 0; i < COUNT; i++) begin
      acc = data_q[i];
      for (int j = 1; j < d; j++) begin
        acc = acc ^ rnd_bus[(j - 1) * COUNT + i];
        enc_sh[sh_idx(i, j, d)] = rnd_bus[(j - 1) * COUNT + i];
      end
      enc_sh[sh_idx(i, 0, d)] = acc;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    out_d     = out_q;
    in_ready  = 1'b0;
    rnd_ready = 1'b0;
    start     = 1'b0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_data;
          start   = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        rnd_ready = 1'b1;
        if (done) begin
          state_d = StEnc;
        end
      end
      StEnc: begin
        out_d   = enc_sh;
        state_d = StOut;
      end
      StOut: begin
        // Bubble-free hand-off: the next word may enter as the current sharing leaves.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            data_d  = in_data;
            start   = 1'b1;
            state_d = StFill;
          end else begin
            data_d  = '0;
            out_d   = '0;
            clear   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!rst_n) begin
      in_ready  = 1'b0;
      rnd_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

  assign out_sh    = out_q;
  assign out_valid = (state_q == StOut);

endmodule

// File: tb/tb_msk_share_encoder.sv
// Self-checking bench: directed scenarios plus randomized beats against a share-level model.
module tb_msk_share_encoder;

  localparam int unsigned D   = 3;
  localparam int unsigned CNT = 8;
  localparam int unsigned RW  = 4;
  localparam int unsigned NB  = ((D - 1) * CNT + RW - 1) / RW;
  localparam int unsigned OW  = CNT * D;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance B: d=3, COUNT=8, RND_W=4
  logic [CNT-1:0] in_data;
  logic           in_valid, in_ready;
  logic [RW-1:0]  rnd_data;
  logic           rnd_valid, rnd_ready;
  logic [OW-1:0]  out_sh;
  logic           out_valid, out_ready;

  // Instance A: d=2, COUNT=8, RND_W=8
  logic [7:0]  a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [7:0]  a_rnd_data;
  logic        a_rnd_valid, a_rnd_ready;
  logic [15:0] a_out_sh;
  logic        a_out_valid, a_out_ready;

  msk_share_encoder #(.d(D), .COUNT(CNT), .RND_W(RW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rnd_data  (rnd_data),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .out_sh    (out_sh),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  msk_share_encoder #(.d(2), .COUNT(8), .RND_W(8)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .rnd_data  (a_rnd_data),
    .rnd_valid (a_rnd_valid),
    .rnd_ready (a_rnd_ready),
    .out_sh    (a_out_sh),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: share j>=1 is the j-th COUNT-bit slice of the beat stream, share 0 fixes the XOR.
  function automatic logic [OW-1:0] model_sh(input logic [CNT-1:0] x, input logic [63:0] pool);
    logic [CNT-1:0] sh [D];
    logic [OW-1:0]  r;
    r     = '0;
    sh[0] = x;
    for (int j = 1; j < D; j++) begin
      sh[j] = pool[(j - 1) * CNT +: CNT];
      sh[0] = sh[0] ^ sh[j];
    end
    for (int i = 0; i < CNT; i++)
      for (int j = 0; j < D; j++) r[i * D + j] = sh[j][i];
    return r;
  endfunction

  function automatic logic [CNT-1:0] share_of(input logic [OW-1:0] s, input int j);
    logic [CNT-1:0] w;
    for (int i = 0; i < CNT; i++) w[i] = s[i * D + j];
    return w;
  endfunction

  function automatic logic [CNT-1:0] recombine(input logic [OW-1:0] s);
    logic [CNT-1:0] w;
    w = '0;
    for (int j = 0; j < D; j++) w = w ^ share_of(s, j);
    return w;
  endfunction

  task automatic accept(input logic [CNT-1:0] x);
    in_data  = x;
    in_valid = 1'b1;
    #1;
    check("accept_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    in_data  = CNT'($urandom);
  endtask

  // mode 0: random beats every cycle, 1: rnd_valid toggling, 2: beats 1,2,3,...
  task automatic gather(input logic [CNT-1:0] x, input int mode, input int exp_lat);
    int          lat;
    int          nb;
    bit          tog;
    logic [63:0] pool;
    lat  = 0;
    nb   = 0;
    tog  = 1'b1;
    pool = '0;
    while (!out_valid && lat < 60) begin
      check("fill_in_ready", in_ready, 0);
      if (mode == 1) begin
        rnd_valid = tog;
        tog       = !tog;
      end else begin
        rnd_valid = 1'b1;
      end
      rnd_data = (mode == 2) ? RW'(nb + 1) : RW'($urandom);
      if (rnd_valid && rnd_ready) begin
        pool = pool | (64'(rnd_data) << (nb * RW));
        nb++;
      end
      step();
      lat++;
    end
    if (mode != 0) rnd_valid = 1'b0;
    check("out_valid_timeout", out_valid, 1);
    check("beats_used", nb, NB);
    if (exp_lat > 0) check("latency", lat, exp_lat);
    check("out_sh", out_sh, model_sh(x, pool));
    check("recombine", recombine(out_sh), x);
    check("out_rnd_ready", rnd_ready, 0);
  endtask

  initial begin
    logic [15:0]    a_exp;
    logic [7:0]     s0, s1;
    logic [CNT-1:0] x;
    logic [OW-1:0]  held;
    logic [CNT-1:0] words [3];
    int             t_prev;

    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    rnd_data    = '0;
    rnd_valid   = 1'b0;
    out_ready   = 1'b1;
    a_in_data   = '0;
    a_in_valid  = 1'b0;
    a_rnd_data  = '0;
    a_rnd_valid = 1'b0;
    a_out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", in_ready, 0);
    check("rst_rnd_ready", rnd_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sh", out_sh, 0);
    check("rst_a_in_ready", a_in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);
    check("idle_a_in_ready", a_in_ready, 1);

    // Scenario 1: d=2, 0xA5 with randomness 0x3C
    a_in_data   = 8'hA5;
    a_in_valid  = 1'b1;
    a_rnd_data  = 8'h3C;
    a_rnd_valid = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("s1_out_valid_c1", a_out_valid, 0);
    check("s1_rnd_ready_c1", a_rnd_ready, 1);
    step();
    a_rnd_valid = 1'b0;
    check("s1_out_valid_c2_pre", a_out_valid, 0);
    check("s1_rnd_ready_enc", a_rnd_ready, 0);
    step();
    s0 = 8'h99;
    s1 = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      a_exp[2 * i]     = s0[i];
      a_exp[2 * i + 1] = s1[i];
    end
    check("s1_out_valid", a_out_valid, 1);
    check("s1_out_sh", a_out_sh, a_exp);
    step();
    check("s1_back_idle", a_out_valid, 0);

    // Scenario 2: d=3, RND_W=4, beats 1,2,3,4
    x = 8'hC7;
    accept(x);
    gather(x, 2, NB + 1);
    check("s2_r1", share_of(out_sh, 1), 8'h21);
    check("s2_r2", share_of(out_sh, 2), 8'h43);
    step();
    check("s2_idle_out_valid", out_valid, 0);

    // Scenario 3: backpressure for 10 cycles while upstream offers another word
    out_ready = 1'b0;
    x = CNT'($urandom);
    accept(x);
    gather(x, 0, NB + 1);
    held     = out_sh;
    in_data  = ~x;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check("bp_out_sh", out_sh, held);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_rnd_ready", rnd_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_handoff_in_ready", in_ready, 1);
    step();
    check("bp_release", out_valid, 0);
    check("bp_idle_in_ready", in_ready, 1);

    // Scenario 4: back-to-back words
    words[0] = 8'h00;
    words[1] = 8'hFF;
    words[2] = 8'h5A;
    t_prev   = 0;
    for (int w = 0; w < 3; w++) begin
      accept(words[w]);
      if (w > 0) check("b2b_period", cyc - t_prev, NB + 2);
      t_prev = cyc;
      gather(words[w], 0, NB + 1);
    end
    step();
    check("b2b_idle", out_valid, 0);

    // Scenario 5: starved PRNG
    x = CNT'($urandom);
    accept(x);
    gather(x, 1, 0);
    step();
    check("starve_idle", out_valid, 0);

    // Scenario 6: reset inside FILL, then inside OUT
    rnd_valid = 1'b0;
    accept(CNT'($urandom));
    rnd_valid = 1'b1;
    rnd_data  = RW'($urandom);
    step();
    rnd_data = RW'($urandom);
    step();
    rst_n = 1'b0;
    step();
    check("rst_fill_in_ready", in_ready, 0);
    check("rst_fill_rnd_ready", rnd_ready, 0);
    check("rst_fill_out_valid", out_valid, 0);
    check("rst_fill_out_sh", out_sh, 0);
    rst_n = 1'b1;
    #1;
    check("rst_fill_idle", in_ready, 1);
    out_ready = 1'b0;
    x = CNT'($urandom);
    accept(x);
    gather(x, 0, NB + 1);
    rst_n = 1'b0;
    step();
    check("rst_out_in_ready", in_ready, 0);
    check("rst_out_rnd_ready", rnd_ready, 0);
    check("rst_out_out_valid", out_valid, 0);
    check("rst_out_out_sh", out_sh, 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_out_idle", in_ready, 1);
    x = CNT'($urandom);
    accept(x);
    gather(x, 0, NB + 1);
    step();
    check("final_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
